// File: rtl/ram_data_ws_pkg.sv
// Shared definitions for the wait-state data RAM: FSM state encoding,
// the default base address, the LFSR seed and the byte-lane helper.
package ram_data_ws_pkg;

   // FSM states of the access sequencer
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Byte address of word 0 in the RISC-V system bench data map
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

   // Seed loaded into the random wait-state LFSR on reset
   localparam logic [7:0] LFSR_SEED = 8'hA5;

   // Number of byte lanes in a data word
   function automatic int byte_lanes(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/ram_data_ws_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), steps once per cycle with en=1.
// Synchronous active-low reset loads LFSR_SEED.
// Only present when RAM_DATA_RANDWAIT_EN is defined.
`ifdef RAM_DATA_RANDWAIT_EN
module ram_data_ws_lfsr8
   import ram_data_ws_pkg::*;
(
   input  logic       Clk,
   input  logic       reset,
   input  logic       en,
   output logic [7:0] q
);

   // Shift left, feeding back the XOR of stages 8,6,5,4
   always_ff @(posedge Clk) begin
      if (!reset) begin
         q <= LFSR_SEED;
      end else if (en) begin
         q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
      end
   end

endmodule
`endif

// File: rtl/ram_data_ws.sv
// Wait-state data memory for the RISC-V system bench.
// A request is accepted in IDLE (or in RESP for back-to-back traffic),
// waits the programmed number of cycles and then answers with a one-cycle
// ready strobe carrying data_out/err.
// Optional macro RAM_DATA_RANDWAIT_EN adds 0..3 pseudo-random extra wait
// states per access, drawn from an 8-bit LFSR.
//
// Handshake: req with its qualifiers (wr/add/be/data_in) is sampled at a
// rising edge while the FSM is in IDLE or RESP; the requester holds them
// stable until ready=1 and drops req in the ready cycle unless it starts
// the next access there. ready is high for exactly one cycle per access,
// and data_out/err are only meaningful while ready=1.
module ram_data_ws
   import ram_data_ws_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter int                DEPTH       = 1024,
   parameter int                WAIT_CYCLES = 2,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR)
) (
   input  logic                  Clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  wr,
   input  logic [ADDR_W-1:0]     add,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [DATA_W-1:0]     data_in,
   output logic                  ready,
   output logic [DATA_W-1:0]     data_out,
   output logic                  err,
   output logic [1:0]            state_dbg
);

   localparam int LANES = byte_lanes(DATA_W);
   localparam int SHIFT = $clog2(LANES);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t              state;
   logic [4:0]          cnt;
   logic [4:0]          wait_cnt;

   logic                lat_wr;
   logic [ADDR_W-1:0]   lat_add;
   logic [LANES-1:0]    lat_be;
   logic [DATA_W-1:0]   lat_data;

   logic                accept;
   logic                enter_resp;
   logic                cur_wr;
   logic [ADDR_W-1:0]   cur_add;
   logic [LANES-1:0]    cur_be;
   logic [DATA_W-1:0]   cur_data;
   logic [ADDR_W-1:0]   offset;
   logic [ADDR_W-1:0]   word;
   logic                cur_err;
   logic [IDX_W-1:0]    cur_idx;

   logic [DATA_W-1:0]   mem [DEPTH];

   assign state_dbg = state;

   // A new access can start from IDLE or directly out of the RESP cycle
   assign accept = req && ((state == ST_IDLE) || (state == ST_RESP));

`ifdef RAM_DATA_RANDWAIT_EN
   logic [7:0] lfsr_q;

   ram_data_ws_lfsr8 u_lfsr (
      .Clk   (Clk),
      .reset (reset),
      .en    (accept),
      .q     (lfsr_q)
   );

   // Fixed wait plus 0..3 extra cycles from the LFSR value at accept time
   always_comb begin
      wait_cnt = 5'(WAIT_CYCLES) + {3'b000, lfsr_q[1:0]};
   end
`else
   // Fixed wait only
   always_comb begin
      wait_cnt = 5'(WAIT_CYCLES);
   end
`endif

   // Response starts now: zero-wait accept, or the last WAIT cycle
   assign enter_resp = (accept && (wait_cnt == 5'd0)) ||
                       ((state == ST_WAIT) && (cnt == 5'd1));

   // Pick the access being completed: latched copy while waiting, live inputs
   // when a zero-wait request goes straight to RESP
   always_comb begin
      cur_wr   = wr;
      cur_add  = add;
      cur_be   = be;
      cur_data = data_in;
      if (state == ST_WAIT) begin
         cur_wr   = lat_wr;
         cur_add  = lat_add;
         cur_be   = lat_be;
         cur_data = lat_data;
      end
   end

   // Address decode: misaligned, below base or past the last word is an error
   always_comb begin
      offset  = cur_add - BASE_ADDR;
      word    = offset >> SHIFT;
      cur_err = ((cur_add & ADDR_W'(LANES - 1)) != '0) ||
                (cur_add < BASE_ADDR) ||
                (word >= ADDR_W'(DEPTH));
      cur_idx = word[IDX_W-1:0];
   end

   // Sequencer: state, wait counter, request latch and registered response
   always_ff @(posedge Clk) begin
      if (!reset) begin
         state    <= ST_IDLE;
         cnt      <= 5'd0;
         ready    <= 1'b0;
         err      <= 1'b0;
         data_out <= '0;
         lat_wr   <= 1'b0;
         lat_add  <= '0;
         lat_be   <= '0;
         lat_data <= '0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         if (accept) begin
            lat_wr   <= wr;
            lat_add  <= add;
            lat_be   <= be;
            lat_data <= data_in;
            cnt      <= wait_cnt;
         end
         unique case (state)
            ST_IDLE, ST_RESP: begin
               if (req) begin
                  state <= (wait_cnt == 5'd0) ? ST_RESP : ST_WAIT;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  state <= ST_RESP;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
         if (enter_resp) begin
            ready <= 1'b1;
            err   <= cur_err;
            if (cur_err) begin
               data_out <= '0;
            end else if (!cur_wr) begin
               data_out <= mem[cur_idx];
            end
         end
      end
   end

   // Byte-lane write as the access enters RESP; errored accesses never write
   always_ff @(posedge Clk) begin
      if (reset && enter_resp && cur_wr && !cur_err) begin
         for (int i = 0; i < LANES; i++) begin
            if (cur_be[i]) begin
               mem[cur_idx][i*8 +: 8] <= cur_data[i*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_data_ws.sv
// Bench for ram_data_ws: three instances with WAIT_CYCLES 2, 0 and 1 share
// clock and reset. A word-array model of each memory supplies expected data.
module tb_ram_data_ws;

   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int          DEPTH = 64;
`ifdef RAM_DATA_RANDWAIT_EN
   localparam int          EXTRA = 3;
`else
   localparam int          EXTRA = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_v   [3];
   logic        wr_v    [3];
   logic [31:0] add_v   [3];
   logic [3:0]  be_v    [3];
   logic [31:0] din_v   [3];
   logic        ready_v [3];
   logic [31:0] dout_v  [3];
   logic        err_v   [3];
   logic [1:0]  st_v    [3];

   logic [31:0] mdl [3][DEPTH];
   logic [31:0] exp_q [$];
   int          n_err = 0;
   int          n_chk = 0;

   typedef struct {
      logic        wr;
      logic [31:0] add;
      logic [3:0]  be;
      logic [31:0] din;
      logic        exp_err;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t tbl [14];

   // Clock
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 0) ? 2 : ((g == 1) ? 0 : 1);
      ram_data_ws #(
         .DATA_W      (32),
         .ADDR_W      (32),
         .DEPTH       (DEPTH),
         .WAIT_CYCLES (W),
         .BASE_ADDR   (BASE)
      ) u_dut (
         .Clk       (clk),
         .reset     (rst_n),
         .req       (req_v[g]),
         .wr        (wr_v[g]),
         .add       (add_v[g]),
         .be        (be_v[g]),
         .data_in   (din_v[g]),
         .ready     (ready_v[g]),
         .data_out  (dout_v[g]),
         .err       (err_v[g]),
         .state_dbg (st_v[g])
      );
   end

   function automatic int wc(input int d);
      case (d)
         0:       return 2;
         1:       return 0;
         default: return 1;
      endcase
   endfunction

   function automatic logic m_err(input logic [31:0] a);
      if (a < BASE) return 1'b1;
      if ((a % 4) != 0) return 1'b1;
      return ((a - BASE) / 4) >= 32'(DEPTH);
   endfunction

   function automatic void m_write(input int d, input logic [31:0] a,
                                   input logic [3:0] b, input logic [31:0] di);
      int idx;
      if (!m_err(a)) begin
         idx = int'((a - BASE) / 4);
         for (int i = 0; i < 4; i++)
            if (b[i]) mdl[d][idx][8*i +: 8] = di[8*i +: 8];
      end
   endfunction

   function automatic logic [31:0] m_read(input int d, input logic [31:0] a);
      if (m_err(a)) return 32'h0;
      return mdl[d][int'((a - BASE) / 4)];
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
         1:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
         2:       return BASE - 32'(4 * $urandom_range(1, 8));
         default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_lat(input string name, input int lat, input int d);
      int lo;
      int hi;
      lo = wc(d) + 1;
      hi = lo + EXTRA;
      n_chk++;
      if (lat < lo || lat > hi) begin
         n_err++;
         $display("FAIL %s: latency %0d want %0d..%0d at %0t", name, lat, lo, hi, $time);
      end
   endtask

   // Driver: issue one access at a negedge and wait (bounded) for ready
   task automatic do_access(input int d, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] di,
                            output logic [31:0] dout, output logic e, output int lat);
      logic done;
      req_v[d] = 1'b1;
      wr_v[d]  = w;
      add_v[d] = a;
      be_v[d]  = b;
      din_v[d] = di;
      @(posedge clk);
      lat  = 0;
      done = 1'b0;
      dout = 32'h0;
      e    = 1'b0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (ready_v[d]) begin
            dout = dout_v[d];
            e    = err_v[d];
            done = 1'b1;
         end
      end
      if (!done) begin
         n_chk++;
         n_err++;
         $display("FAIL timeout: dut %0d no ready within %0d cycles", d, lat);
      end
      req_v[d] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Main test sequence
   initial begin
      logic [31:0] dout;
      logic        e;
      int          lat;
      logic [31:0] a;
      logic [31:0] di;
      logic [3:0]  b;
      logic        w;
      int          d;
      int          ready_seen;
      int          lat_a [16];
      logic [31:0] ra    [16];
      logic [31:0] bb_a  [4];
      logic [31:0] old_w;

      tbl[0]  = '{1'b1, 32'h1001_0004, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 32'h1001_0004, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 32'h1001_0008, 4'hF, 32'h11223344, 1'b0, 32'h0};
      tbl[3]  = '{1'b1, 32'h1001_0008, 4'h5, 32'hAABBCCDD, 1'b0, 32'h0};
      tbl[4]  = '{1'b0, 32'h1001_0008, 4'h0, 32'h0,        1'b0, 32'h11BB33DD};
      tbl[5]  = '{1'b0, 32'h1001_0002, 4'h0, 32'h0,        1'b1, 32'h0};
      tbl[6]  = '{1'b1, 32'h1001_0000, 4'hF, 32'h01020304, 1'b0, 32'h0};
      tbl[7]  = '{1'b1, 32'h1001_0100, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
      tbl[8]  = '{1'b0, 32'h1001_0000, 4'h0, 32'h0,        1'b0, 32'h01020304};
      tbl[9]  = '{1'b1, 32'h1001_0000, 4'h0, 32'h55555555, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 32'h1001_0000, 4'h0, 32'h0,        1'b0, 32'h01020304};
      tbl[11] = '{1'b0, 32'h1000_FFFC, 4'h0, 32'h0,        1'b1, 32'h0};
      tbl[12] = '{1'b1, 32'h1001_00FC, 4'hF, 32'h0BADF00D, 1'b0, 32'h0};
      tbl[13] = '{1'b0, 32'h1001_00FC, 4'h0, 32'h0,        1'b0, 32'h0BADF00D};

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_v[i] = 1'b0;
         wr_v[i]  = 1'b0;
         add_v[i] = 32'h0;
         be_v[i]  = 4'h0;
         din_v[i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("reset_ready", 32'(ready_v[i]), 32'h0);
         chk("reset_err",   32'(err_v[i]),   32'h0);
         chk("reset_dout",  dout_v[i],       32'h0);
         chk("reset_state", 32'(st_v[i]),    32'h0);
      end
      rst_n = 1'b1;

      // Fill every word of every instance so the model is fully defined
      for (int dd = 0; dd < 3; dd++) begin
         for (int i = 0; i < DEPTH; i++) begin
            a  = BASE + 32'(4 * i);
            di = $urandom;
            do_access(dd, 1'b1, a, 4'hF, di, dout, e, lat);
            m_write(dd, a, 4'hF, di);
            chk("fill_err", 32'(e), 32'h0);
            chk_lat("fill_lat", lat, dd);
         end
      end

      // Directed vectors on the WAIT_CYCLES=2 instance
      for (int i = 0; i < 14; i++) begin
         do_access(0, tbl[i].wr, tbl[i].add, tbl[i].be, tbl[i].din, dout, e, lat);
         if (tbl[i].wr) m_write(0, tbl[i].add, tbl[i].be, tbl[i].din);
         chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
         if (!tbl[i].wr || tbl[i].exp_err)
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
         chk_lat($sformatf("tbl%0d_lat", i), lat, 0);
      end

      // Back-to-back reads on the WAIT_CYCLES=0 instance
      for (int i = 0; i < 4; i++) bb_a[i] = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
`ifndef RAM_DATA_RANDWAIT_EN
      req_v[1] = 1'b1;
      wr_v[1]  = 1'b0;
      add_v[1] = bb_a[0];
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("b2b%0d_ready", i), 32'(ready_v[1]), 32'h1);
         chk($sformatf("b2b%0d_dout", i), dout_v[1], m_read(1, bb_a[i]));
         if (i < 3) add_v[1] = bb_a[i+1];
         else req_v[1] = 1'b0;
      end
`else
      for (int i = 0; i < 4; i++) begin
         do_access(1, 1'b0, bb_a[i], 4'h0, 32'h0, dout, e, lat);
         chk($sformatf("b2b%0d_dout", i), dout, m_read(1, bb_a[i]));
         chk_lat("b2b_lat", lat, 1);
      end
`endif

      // Reset one cycle after accepting a write: access must be dropped
      @(negedge clk);
      a     = BASE + 32'h10;
      old_w = m_read(0, a);
      req_v[0] = 1'b1;
      wr_v[0]  = 1'b1;
      add_v[0] = a;
      be_v[0]  = 4'hF;
      din_v[0] = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b0;
      req_v[0] = 1'b0;
      ready_seen = 0;
      @(posedge clk);
      @(negedge clk);
      chk("rstwait_ready", 32'(ready_v[0]), 32'h0);
      chk("rstwait_err",   32'(err_v[0]),   32'h0);
      chk("rstwait_dout",  dout_v[0],       32'h0);
      chk("rstwait_state", 32'(st_v[0]),    32'h0);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (ready_v[0]) ready_seen++;
      end
      chk("rstwait_no_ready", 32'(ready_seen), 32'h0);
      do_access(0, 1'b0, a, 4'h0, 32'h0, dout, e, lat);
      chk("rstwait_word_kept", dout, old_w);

      // Random traffic against the model
      for (int k = 0; k < 150; k++) begin
         d  = $urandom_range(0, 2);
         a  = rand_addr();
         w  = 1'($urandom_range(0, 1));
         b  = 4'($urandom_range(0, 15));
         di = $urandom;
         if (!w) exp_q.push_back(m_read(d, a));
         do_access(d, w, a, b, di, dout, e, lat);
         chk("rand_err", 32'(e), 32'(m_err(a)));
         chk_lat("rand_lat", lat, d);
         if (w) m_write(d, a, b, di);
         else chk("rand_dout", dout, exp_q.pop_front());
      end

      // Latency sequence on the WAIT_CYCLES=1 instance, twice from reset
      do_reset();
      for (int i = 0; i < 16; i++) begin
         ra[i] = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         do_access(2, 1'b0, ra[i], 4'h0, 32'h0, dout, e, lat);
         chk("rw_a_dout", dout, m_read(2, ra[i]));
         chk_lat("rw_a_lat", lat, 2);
         lat_a[i] = lat;
      end
      do_reset();
      for (int i = 0; i < 16; i++) begin
         do_access(2, 1'b0, ra[i], 4'h0, 32'h0, dout, e, lat);
         chk("rw_b_dout", dout, m_read(2, ra[i]));
         chk("rw_repeat_lat", 32'(lat), 32'(lat_a[i]));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ram_data_ws.md
Name: ram_data_ws

Overview:
- Parametrised, wait-state data memory model for the RISC-V system bench; the successor to the single-cycle data RAM.
- Connects between the core's data port and the bench. Adds a request/ready handshake, byte-lane writes, address-range/alignment error reporting and a programmable access latency.
- Allows the core's stall logic to be exercised against non-ideal memory.

Parameters:
- DATA_W, 32, data word width in bits (multiple of 8).
- ADDR_W, 32, byte address width.
- DEPTH, 1024, number of DATA_W-bit words.
- WAIT_CYCLES, 2, fixed wait states between accept and response (0..15).
- BASE_ADDR, 32'h1001_0000, byte address of word 0.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  access request, qualified with add/wr/be/data_in.
- wr  in  1  1 = write, 0 = read.
- add  in  ADDR_W  byte address.
- be  in  DATA_W/8  byte enables for writes; ignored on reads.
- data_in  in  DATA_W  write data.
- ready  out  1  one-cycle response strobe.
- data_out  out  DATA_W  read data, valid while ready=1.
- err  out  1  access error, valid while ready=1.

Behaviour:
- Reset (reset=0 at rising edge):
  - State goes to IDLE; ready=0, err=0, data_out=0, wait counter=0.
  - Memory array is not cleared.
  - Reset during WAIT aborts the access; no write occurs.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if req=1, latch add/wr/be/data_in, load counter with the wait count, then go to WAIT; if the wait count is 0, go directly to RESP.
  - WAIT: counter decrements each cycle; when counter==1, next state is RESP. req is ignored.
  - RESP: ready=1 for exactly this cycle. If req=1 in this cycle, the new request is latched (back-to-back) and the next state is WAIT or RESP per the wait count; otherwise go to IDLE.
- Latency: ready asserts WAIT_CYCLES+1 cycles after the accept edge. Maximum throughput is one access per WAIT_CYCLES+1 cycles.
- Address decode: index = (add - BASE_ADDR) >> log2(DATA_W/8).
  - err=1 when the low byte-offset bits are nonzero (misaligned), or add < BASE_ADDR, or index >= DEPTH.
- Write, executed at the RESP edge:
  - Each byte lane i with be[i]=1 is written; other lanes are unchanged.
  - be=0 is legal: no change, err=0.
  - On err, no write occurs.
- Read: data_out is registered with mem[index] on entry to RESP.
  - On err, data_out=0.
  - Outside RESP, data_out holds its last value; ready=0 and err=0.
- Requester protocol: hold req and its qualifiers stable until ready; deassert req in the ready cycle unless issuing a back-to-back access.

Optional Feature:
- Macro: RAM_DATA_RANDWAIT_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances once per accepted request.
  - Wait count = WAIT_CYCLES + lfsr[1:0], giving 0..3 extra cycles.
  - The LFSR resets with reset.
- Undefined: wait count = WAIT_CYCLES exactly; no LFSR logic is instantiated.

Decomposition:
- Shared header ram_defs.vh holds:
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Default BASE_ADDR.
  - Byte-lane count macro.
- Natural sub-module: lfsr8, 8-bit enable-stepped LFSR with synchronous active-low reset, instantiated only under RAM_DATA_RANDWAIT_EN.

Test Plan:
- Write then read, WAIT_CYCLES=2: write 32'hDEADBEEF at 32'h1001_0004, be=4'hF. Required: ready 3 cycles after accept, err=0. Reading the same address returns 32'hDEADBEEF.
- Byte lanes: word holds 32'h11223344; write 32'hAABBCCDD with be=4'b0101. Required: read returns 32'h11BB33DD.
- Errors:
  - Read at 32'h1001_0002 (misaligned): ready with err=1, data_out=0.
  - Write at BASE_ADDR+4*DEPTH: err=1; word 0 is unchanged.
- Back-to-back, WAIT_CYCLES=0: req held high over 4 reads. Required: ready every cycle after the first accept, correct data per address.
- Reset mid-WAIT: reset=0 issued one cycle after accepting a write of 32'hCAFEF00D. Required: ready never asserts, outputs are 0, the target word keeps its old value.
- With RAM_DATA_RANDWAIT_EN: 16 reads, WAIT_CYCLES=1. Required: every latency lies in 2..5, the latency sequence is identical across two runs, and the data is correct.
